// File: rtl/button_debounce.sv
// Push-button conditioner: synchronises a raw pin, rejects contact bounce and
// produces a clean level plus registered press, release and long-hold strobes.
module button_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 0,
  parameter int unsigned CNT_WIDTH       = 20,
  parameter int unsigned ACTIVE_LOW      = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse,
  output logic held
);

  localparam logic [1:0] ST_UP     = 2'd0;
  localparam logic [1:0] ST_CHK_DN = 2'd1;
  localparam logic [1:0] ST_DOWN   = 2'd2;
  localparam logic [1:0] ST_CHK_UP = 2'd3;

  localparam logic [CNT_WIDTH-1:0] DB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_MAX  = CNT_WIDTH'(HOLD_CYCLES);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST =
    CNT_WIDTH'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
  localparam logic HOLD_EN = (HOLD_CYCLES != 0);

  logic                   w_b;
  logic                   w_s;
  logic [SYNC_STAGES-1:0] r_sync;

  logic [1:0]           r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_hcnt, w_hcnt_nxt;
  logic                 r_level, w_level_nxt;
  logic                 r_press, w_press_nxt;
  logic                 r_release, w_release_nxt;
  logic                 r_hold, w_hold_nxt;
  logic                 r_held, w_held_nxt;

  // Polarity is normalised before the first flop so the chain resets to "not pressed".
  assign w_b = button ^ 1'(ACTIVE_LOW);
  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_UP;
      r_cnt     <= '0;
      r_hcnt    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_hold    <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_hold    <= w_hold_nxt;
      r_held    <= w_held_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hcnt_nxt    = r_hcnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_hold_nxt    = 1'b0;
    w_held_nxt    = r_held;
    case (r_state)
      ST_UP: begin
        if (w_s) begin
          w_state_nxt = ST_CHK_DN;
          w_cnt_nxt   = '0;
        end
      end
      ST_CHK_DN: begin
        if (!w_s) begin
          w_state_nxt = ST_UP;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = ST_DOWN;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
          w_hcnt_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end
      ST_DOWN: begin
        // Hold count only advances here; a release bounce pauses it.
        if (r_hcnt != HOLD_MAX) begin
          w_hcnt_nxt = r_hcnt + CNT_WIDTH'(1);
        end
        if (HOLD_EN && (r_hcnt == HOLD_LAST) && !r_held) begin
          w_hold_nxt = 1'b1;
          w_held_nxt = 1'b1;
        end
        if (!w_s) begin
          w_state_nxt = ST_CHK_UP;
          w_cnt_nxt   = '0;
        end
      end
      ST_CHK_UP: begin
        if (w_s) begin
          w_state_nxt = ST_DOWN;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt   = ST_UP;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
          w_held_nxt    = 1'b0;
          w_hcnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = ST_UP;
      end
    endcase
  end

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign hold_pulse    = r_hold;
  assign held          = r_held;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: three instances (hold on, hold off,
// active-low pin) driven from one stimulus, with strobe timing and invariant checks.
module tb_button_debounce;

  logic clk;
  logic rst;
  logic button;
  logic pin_c;
  logic lvl [3];
  logic prs [3];
  logic rls [3];
  logic hp  [3];
  logic hld [3];

  int cyc;
  int n_checks;
  int n_errors;
  int viol;
  int pc [3];
  int rc [3];
  int hc [3];
  int last_p [3];
  int last_r [3];
  int last_h [3];
  logic prev_lvl [3];
  logic pressed_seen [3];
  logic rst_seen;

  assign pin_c = ~button;

  button_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20),
                    .CNT_WIDTH(8), .ACTIVE_LOW(0)) u_a (
    .clk(clk), .rst(rst), .button(button), .btn_level(lvl[0]), .press_pulse(prs[0]),
    .release_pulse(rls[0]), .hold_pulse(hp[0]), .held(hld[0]));

  button_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(0),
                    .CNT_WIDTH(8), .ACTIVE_LOW(0)) u_b (
    .clk(clk), .rst(rst), .button(button), .btn_level(lvl[1]), .press_pulse(prs[1]),
    .release_pulse(rls[1]), .hold_pulse(hp[1]), .held(hld[1]));

  button_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20),
                    .CNT_WIDTH(8), .ACTIVE_LOW(1)) u_c (
    .clk(clk), .rst(rst), .button(pin_c), .btn_level(lvl[2]), .press_pulse(prs[2]),
    .release_pulse(rls[2]), .hold_pulse(hp[2]), .held(hld[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // Strobe logging (edge number of each strobe) and invariant monitoring.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (int'(prs[i]) + int'(rls[i]) + int'(hp[i]) > 1) viol++;
      if (prs[i]) begin pc[i]++; last_p[i] = cyc; end
      if (rls[i]) begin rc[i]++; last_r[i] = cyc; end
      if (hp[i])  begin hc[i]++; last_h[i] = cyc; end
      if (rst_seen) begin
        pressed_seen[i] = 1'b0;
      end else begin
        if ((lvl[i] != prev_lvl[i]) && !prs[i] && !rls[i]) viol++;
        if (prs[i] && pressed_seen[i]) viol++;
        if (rls[i] && !pressed_seen[i]) viol++;
        if (prs[i]) pressed_seen[i] = 1'b1;
        if (rls[i]) pressed_seen[i] = 1'b0;
      end
      prev_lvl[i] = lvl[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic [4:0] outs(input int i);
    return {lvl[i], prs[i], rls[i], hp[i], hld[i]};
  endfunction

  int m;
  int pc0;
  int rc0;

  initial begin
    rst    = 1'b1;
    button = 1'b0;
    tick(2);
    check("rst_outs_a", 32'(outs(0)), 0);
    check("rst_outs_b", 32'(outs(1)), 0);
    check("rst_outs_c", 32'(outs(2)), 0);
    rst = 1'b0;
    tick(3);

    // Clean press, held long enough to see the hold strobe; change sampled at edge m+1.
    m = cyc;
    button = 1'b1;
    tick(10);
    check("press_cnt_a", pc[0], 1);
    check("press_edge_a", last_p[0], m + 7);
    check("level_a", 32'(lvl[0]), 1);
    check("press_edge_b", last_p[1], m + 7);
    check("press_edge_al", last_p[2], m + 7);
    check("level_al", 32'(lvl[2]), 1);
    tick(30);
    check("hold_cnt_a", hc[0], 1);
    check("hold_edge_a", last_h[0], m + 27);
    check("held_a", 32'(hld[0]), 1);
    check("hold_cnt_b", hc[1], 0);
    check("held_b", 32'(hld[1]), 0);
    check("hold_edge_al", last_h[2], m + 27);

    m = cyc;
    button = 1'b0;
    tick(10);
    check("rel_cnt_a", rc[0], 1);
    check("rel_edge_a", last_r[0], m + 7);
    check("rel_level_a", 32'(lvl[0]), 0);
    check("rel_held_a", 32'(hld[0]), 0);
    check("rel_edge_al", last_r[2], m + 7);

    // Press bounce: high 3 / low 1, five times, then steady high.
    for (int r = 0; r < 5; r++) begin
      button = 1'b1; tick(3);
      button = 1'b0; tick(1);
    end
    check("bounce_no_press", pc[0], 1);
    m = cyc;
    button = 1'b1;
    tick(10);
    check("bounce_press_cnt", pc[0], 2);
    check("bounce_press_edge", last_p[0], m + 7);

    // Release bounce: low 2 / high 1, four times, then steady low.
    for (int r = 0; r < 4; r++) begin
      button = 1'b0; tick(2);
      button = 1'b1; tick(1);
    end
    check("relbounce_level", 32'(lvl[0]), 1);
    check("relbounce_no_rel", rc[0], 1);
    m = cyc;
    button = 1'b0;
    tick(10);
    check("relbounce_rel_cnt", rc[0], 2);
    check("relbounce_rel_edge", last_r[0], m + 7);
    check("relbounce_no_hold", hc[0], 1);

    // Reset while in the press-debounce window.
    pc0 = pc[0];
    button = 1'b1;
    tick(4);
    rst = 1'b1;
    button = 1'b0;
    tick(1);
    check("rst_chkdn_outs", 32'(outs(0)), 0);
    rst = 1'b0;
    tick(10);
    check("rst_chkdn_no_press", pc[0], pc0);

    // Reset while DOWN with held set: no release strobe may appear.
    button = 1'b1;
    tick(35);
    check("pre_rst_held", 32'(hld[0]), 1);
    rc0 = rc[0];
    rst = 1'b1;
    button = 1'b0;
    tick(1);
    check("rst_down_outs_a", 32'(outs(0)), 0);
    check("rst_down_outs_al", 32'(outs(2)), 0);
    rst = 1'b0;
    tick(10);
    check("rst_down_no_rel", rc[0], rc0);

    // Clean press again after reset.
    pc0 = pc[0];
    m = cyc;
    button = 1'b1;
    tick(10);
    check("post_rst_press_cnt", pc[0], pc0 + 1);
    check("post_rst_press_edge", last_p[0], m + 7);
    button = 1'b0;
    tick(12);
    check("hold_never_b", hc[1], 0);
    check("invariants", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
